// File: rtl/syn_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO (syn_fifo_v3).
package syn_fifo_pkg;

  // Default geometry: 16-bit words, 16 entries.
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Count-decode constants: almost_full defaults to DEPTH - AF_MARGIN,
  // almost_empty defaults to DEFAULT_AE_THRESH.
  localparam int AF_MARGIN         = 2;
  localparam int DEFAULT_AE_THRESH = 2;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage : syn_fifo_pkg

// File: rtl/syn_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
module syn_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage write; stale contents are never observable because the pointers reset.
  // NOTE: the array has no reset so it maps onto plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its last value when no read is requested.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule : syn_fifo_mem

// File: rtl/syn_fifo_v3.sv
// Single-clock parametrised FIFO with fill count, almost-full/almost-empty
// thresholds, registered read with valid strobe and synchronous flush.
// Optional: define SYN_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module syn_fifo_v3
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = 2 ** ADDR_WIDTH - AF_MARGIN,
  parameter int AE_THRESH  = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  empty,
  output logic                  almost_empty,
`ifdef SYN_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int              PW       = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0]   AF_LEVEL = PW'(AF_THRESH);
  localparam logic [PW-1:0]   AE_LEVEL = PW'(AE_THRESH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_accept;
  logic          rd_accept;

  // Flags and count decode from the registered pointers only.
  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    almost_full  = (count >= AF_LEVEL);
    almost_empty = (count <= AE_LEVEL);
  end

  // Flush blocks both ports; full/empty gate each side independently.
  assign wr_accept = wr_en && !full  && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  // Write pointer: advances on each accepted write, wraps through the MSB.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Read pointer and valid strobe: one-cycle latency behind an accepted read.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rd_ptr     <= '0;
      read_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_accept;
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

`ifdef SYN_FIFO_ERR_FLAGS_EN
  // Sticky error flags for rejected accesses; cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

  syn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset_l (reset_l),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (write_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (read_data)
  );

endmodule : syn_fifo_v3

// File: tb/tb_syn_fifo_v3.sv
// Directed self-checking bench for syn_fifo_v3 (16 x 16, AF=14, AE=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_syn_fifo_v3;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        flush;
  logic        wr_en;
  logic [15:0] write_data;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [15:0] read_data;
  logic        read_valid;
  logic        empty;
  logic        almost_empty;
  logic [4:0]  count;
`ifdef SYN_FIFO_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  syn_fifo_v3 #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (4),
    .AF_THRESH  (14),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .flush        (flush),
    .wr_en        (wr_en),
    .write_data   (write_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
`ifdef SYN_FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_l = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; write_data = '0;
    @(negedge clk);
    vec_count++;
    if ({count, full, almost_full, empty, almost_empty, read_valid} !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL reset_flags: got cnt=%0d f=%b af=%b e=%b ae=%b v=%b, want cnt=0 f=0 af=0 e=1 ae=1 v=0",
               count, full, almost_full, empty, almost_empty, read_valid);
    end
    vec_count++;
    if (read_data !== 16'h0000) begin
      err_count++; $display("FAIL reset_data: got %h want 0000", read_data);
    end
    reset_l = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; write_data = 16'(i);
      tick();
      vec_count++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) ||
          full !== (i + 1 == 16) || almost_empty !== (i + 1 <= 2) || empty !== 1'b0) begin
        err_count++;
        $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b ae=%b e=%b, want cnt=%0d af=%b f=%b ae=%b e=0",
                 i, count, almost_full, full, almost_empty, empty,
                 i + 1, (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2));
      end
    end
    write_data = 16'hDEAD;
    tick();
    wr_en = 1'b0;
    vec_count++;
    if (count !== 5'd16 || full !== 1'b1) begin
      err_count++; $display("FAIL fill_overwrite: got cnt=%0d f=%b want cnt=16 f=1", count, full);
    end
`ifdef SYN_FIFO_ERR_FLAGS_EN
    vec_count++;
    if (overflow !== 1'b1) begin
      err_count++; $display("FAIL overflow_set: got %b want 1", overflow);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      vec_count++;
      if (read_valid !== 1'b1 || read_data !== 16'(i) || count !== 5'(15 - i)) begin
        err_count++;
        $display("FAIL drain_%0d: got v=%b d=%h cnt=%0d, want v=1 d=%h cnt=%0d",
                 i, read_valid, read_data, count, 16'(i), 15 - i);
      end
    end
    vec_count++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin
      err_count++; $display("FAIL drain_empty: got e=%b ae=%b f=%b want e=1 ae=1 f=0", empty, almost_empty, full);
    end
    tick();
    rd_en = 1'b0;
    vec_count++;
    if (read_valid !== 1'b0 || read_data !== 16'h000F || count !== 5'd0) begin
      err_count++;
      $display("FAIL drain_underrun: got v=%b d=%h cnt=%0d want v=0 d=000f cnt=0", read_valid, read_data, count);
    end
`ifdef SYN_FIFO_ERR_FLAGS_EN
    vec_count++;
    if (underflow !== 1'b1) begin
      err_count++; $display("FAIL underflow_set: got %b want 1", underflow);
    end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; write_data = 16'h0100 + 16'(i);
      tick();
    end
    vec_count++;
    if (count !== 5'd5) begin
      err_count++; $display("FAIL wrap_prefill: got cnt=%0d want 5", count);
    end
    for (int i = 5; i < 40; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; write_data = 16'h0100 + 16'(i);
      tick();
      vec_count++;
      if (read_valid !== 1'b1 || read_data !== 16'h0100 + 16'(i - 5) || count !== 5'd5) begin
        err_count++;
        $display("FAIL wrap_%0d: got v=%b d=%h cnt=%0d, want v=1 d=%h cnt=5",
                 i, read_valid, read_data, count, 16'h0100 + 16'(i - 5));
      end
    end
    wr_en = 1'b0;
    for (int i = 35; i < 40; i++) begin
      rd_en = 1'b1;
      tick();
      vec_count++;
      if (read_valid !== 1'b1 || read_data !== 16'h0100 + 16'(i)) begin
        err_count++;
        $display("FAIL wrap_tail_%0d: got v=%b d=%h, want v=1 d=%h", i, read_valid, read_data, 16'h0100 + 16'(i));
      end
    end
    rd_en = 1'b0;
    vec_count++;
    if (empty !== 1'b1) begin
      err_count++; $display("FAIL wrap_empty: got e=%b want 1", empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; write_data = 16'h0200 + 16'(i);
      tick();
    end
    rd_en = 1'b1; write_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    vec_count++;
    if (count !== 5'd15 || read_valid !== 1'b1 || read_data !== 16'h0200) begin
      err_count++;
      $display("FAIL simul_full: got cnt=%0d v=%b d=%h want cnt=15 v=1 d=0200", count, read_valid, read_data);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      vec_count++;
      if (read_valid !== 1'b1 || read_data !== 16'h0200 + 16'(i)) begin
        err_count++;
        $display("FAIL simul_drain_%0d: got v=%b d=%h want v=1 d=%h", i, read_valid, read_data, 16'h0200 + 16'(i));
      end
    end
    vec_count++;
    if (empty !== 1'b1) begin
      err_count++; $display("FAIL simul_drained: got e=%b want 1 (rejected write leaked)", empty);
    end
    wr_en = 1'b1; write_data = 16'h0300;
    tick();
    wr_en = 1'b0;
    vec_count++;
    if (count !== 5'd1 || read_valid !== 1'b0 || empty !== 1'b0) begin
      err_count++;
      $display("FAIL simul_empty: got cnt=%0d v=%b e=%b want cnt=1 v=0 e=0", count, read_valid, empty);
    end
    tick();
    rd_en = 1'b0;
    vec_count++;
    if (read_valid !== 1'b1 || read_data !== 16'h0300 || empty !== 1'b1) begin
      err_count++;
      $display("FAIL simul_empty_pop: got v=%b d=%h e=%b want v=1 d=0300 e=1", read_valid, read_data, empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; write_data = 16'h0400 + 16'(i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    vec_count++;
    if (count !== 5'd7 || read_data !== 16'h0400 || read_valid !== 1'b1) begin
      err_count++;
      $display("FAIL flush_setup: got cnt=%0d d=%h v=%b want cnt=7 d=0400 v=1", count, read_data, read_valid);
    end
    flush = 1'b1; wr_en = 1'b1; write_data = 16'hAAAA;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    vec_count++;
    if (count !== 5'd0 || empty !== 1'b1 || read_valid !== 1'b0 || read_data !== 16'h0400) begin
      err_count++;
      $display("FAIL flush_clear: got cnt=%0d e=%b v=%b d=%h want cnt=0 e=1 v=0 d=0400",
               count, empty, read_valid, read_data);
    end
`ifdef SYN_FIFO_ERR_FLAGS_EN
    vec_count++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      err_count++; $display("FAIL flush_errflags: got ovf=%b udf=%b want 0 0", overflow, underflow);
    end
`endif
    wr_en = 1'b1; write_data = 16'h0555;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vec_count++;
    if (read_valid !== 1'b1 || read_data !== 16'h0555 || empty !== 1'b1) begin
      err_count++;
      $display("FAIL flush_after: got v=%b d=%h e=%b want v=1 d=0555 e=1", read_valid, read_data, empty);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; write_data = 16'h0600 + 16'(i);
      tick();
    end
    rd_en = 1'b1; write_data = 16'h0603;
    tick();
    vec_count++;
    if (read_valid !== 1'b1 || read_data !== 16'h0600 || count !== 5'd3) begin
      err_count++;
      $display("FAIL areset_setup: got v=%b d=%h cnt=%0d want v=1 d=0600 cnt=3", read_valid, read_data, count);
    end
    write_data = 16'h0604;
    #2 reset_l = 1'b0;
    #1;
    vec_count++;
    if ({count, full, almost_full, empty, almost_empty, read_valid, read_data} !==
        {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
      err_count++;
      $display("FAIL areset_mid: got cnt=%0d f=%b af=%b e=%b ae=%b v=%b d=%h, want cnt=0 f=0 af=0 e=1 ae=1 v=0 d=0000",
               count, full, almost_full, empty, almost_empty, read_valid, read_data);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    reset_l = 1'b1;
    tick();
    vec_count++;
    if (count !== 5'd0 || empty !== 1'b1 || read_valid !== 1'b0) begin
      err_count++;
      $display("FAIL areset_after: got cnt=%0d e=%b v=%b want cnt=0 e=1 v=0", count, empty, read_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule : tb_syn_fifo_v3
